// File: rtl/sevenseg_scan.sv
// Four-digit multiplexed seven-segment scanner with hex decode,
// leading-zero blanking, per-digit decimal points and registered outputs.
module sevenseg_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        digit_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(REFRESH_DIV - 1);

    logic [15:0]   hold_val_q;
    logic [3:0]    hold_dp_q;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;
    logic          tick_q;
    logic          tick;
    logic [3:0]    nib;
    logic [6:0]    dec;
    logic          blank;

    assign tick  = (pre_q == TERM);
    assign pre_d = tick ? '0 : pre_q + 1'b1;
    assign idx_d = idx_q + 2'd1;
    assign nib   = hold_val_q[{idx_d, 2'b00} +: 4];

    always_comb begin
        dec = 7'h00;
        unique case (nib)
            4'h0: dec = 7'h3F;
            4'h1: dec = 7'h06;
            4'h2: dec = 7'h5B;
            4'h3: dec = 7'h4F;
            4'h4: dec = 7'h66;
            4'h5: dec = 7'h6D;
            4'h6: dec = 7'h7D;
            4'h7: dec = 7'h07;
            4'h8: dec = 7'h7F;
            4'h9: dec = 7'h6F;
            4'hA: dec = 7'h77;
            4'hB: dec = 7'h7C;
            4'hC: dec = 7'h39;
            4'hD: dec = 7'h5E;
            4'hE: dec = 7'h79;
            4'hF: dec = 7'h71;
        endcase
    end

    // A digit blanks only if it and every more-significant nibble is zero.
    assign blank = blank_lz && (idx_d != 2'd0) &&
                   ((hold_val_q >> {idx_d, 2'b00}) == 16'h0000);

    assign seg_d = (blank ? 7'h00 : dec) ^ {7{ACTIVE_LOW}};
    assign dp_d  = (~blank & hold_dp_q[idx_d]) ^ ACTIVE_LOW;
    assign an_d  = (4'b0001 << idx_d) ^ {4{ACTIVE_LOW}};

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_val_q <= 16'h0000;
            hold_dp_q  <= 4'h0;
            pre_q      <= '0;
            idx_q      <= 2'd0;
            seg_q      <= {7{ACTIVE_LOW}};
            dp_q       <= ACTIVE_LOW;
            an_q       <= {4{ACTIVE_LOW}};
            tick_q     <= 1'b0;
        end else begin
            if (load) begin
                hold_val_q <= value;
                hold_dp_q  <= dp_in;
            end
            pre_q  <= pre_d;
            tick_q <= tick;
            if (tick) begin
                idx_q <= idx_d;
                seg_q <= seg_d;
                dp_q  <= dp_d;
                an_q  <= an_d;
            end
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign digit_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan: one high-true and one low-true
// instance driven in lockstep, expected digits queued per tick.
module tb_sevenseg_scan;

    localparam int DIV = 4;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg_h, seg_l;
    logic        dp_h, dp_l;
    logic [3:0]  an_h, an_l;
    logic        tk_h, tk_l;

    int total = 0;
    int bad   = 0;

    logic [11:0] q[$];
    logic [15:0] mval;
    logic [3:0]  mdp;
    logic [1:0]  bidx;

    logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    sevenseg_scan #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst(rst), .load(load), .value(value),
        .dp_in(dp_in), .blank_lz(blank_lz),
        .seg(seg_h), .dp(dp_h), .an(an_h), .digit_tick(tk_h)
    );

    sevenseg_scan #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .rst(rst), .load(load), .value(value),
        .dp_in(dp_in), .blank_lz(blank_lz),
        .seg(seg_l), .dp(dp_l), .an(an_l), .digit_tick(tk_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] model(input logic [15:0] v,
                                          input logic [3:0] d,
                                          input logic b,
                                          input logic [1:0] n);
        logic [15:0] up;
        logic [3:0]  a;
        logic        blk;
        up  = v >> (4 * n);
        a   = 4'b0001 << n;
        blk = b && (n != 2'd0) && (up == 16'h0000);
        return {a, blk ? 7'h00 : SEG_TAB[up[3:0]], ~blk & d[n]};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic exp_tick);
        logic [11:0] e;
        chk("tick_h", {11'd0, tk_h}, {11'd0, exp_tick});
        chk("tick_l", {11'd0, tk_l}, {11'd0, exp_tick});
        if (tk_h) begin
            if (q.size() == 0) begin
                chk("queue_empty", 12'd1, 12'd0);
            end else begin
                e = q.pop_front();
                chk("digit_h", {an_h, seg_h, dp_h}, e);
                chk("digit_l", {an_l, seg_l, dp_l}, ~e);
            end
        end
    endtask

    task automatic next_tick(input int ld, input logic [15:0] v,
                             input logic [3:0] d);
        for (int e = 1; e <= DIV; e++) begin
            if (e == ld) begin
                load  = 1'b1;
                value = v;
                dp_in = d;
            end
            if (e == DIV) q.push_back(model(mval, mdp, blank_lz, bidx + 2'd1));
            @(posedge clk);
            @(negedge clk);
            load = 1'b0;
            if (e == ld) begin
                mval = v;
                mdp  = d;
            end
            sample(e == DIV);
        end
        bidx = bidx + 2'd1;
    endtask

    initial begin
        rst = 1'b1; load = 1'b1; value = 16'hFFFF;
        dp_in = 4'hF; blank_lz = 1'b0;
        mval = 16'h0; mdp = 4'h0; bidx = 2'd0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_l", {an_l, seg_l, dp_l, tk_l}, {4'hF, 7'h7F, 1'b1, 1'b0});
            chk("rst_h", {an_h, seg_h, dp_h, tk_h}, 13'h0);
        end
        rst = 1'b0; load = 1'b0; value = 16'h0; dp_in = 4'h0;

        next_tick(0, 16'h0, 4'h0);

        next_tick(1, 16'h1234, 4'h0);
        for (int i = 0; i < 4; i++) next_tick(0, 16'h0, 4'h0);

        blank_lz = 1'b1;
        next_tick(1, 16'h0005, 4'h0);
        for (int i = 0; i < 3; i++) next_tick(0, 16'h0, 4'h0);
        next_tick(2, 16'h0000, 4'h0);
        for (int i = 0; i < 3; i++) next_tick(0, 16'h0, 4'h0);
        next_tick(3, 16'h0100, 4'h0);
        for (int i = 0; i < 3; i++) next_tick(0, 16'h0, 4'h0);

        blank_lz = 1'b0;
        next_tick(1, 16'hAAAA, 4'h0);
        next_tick(DIV, 16'hBBBB, 4'h0);
        next_tick(0, 16'h0, 4'h0);
        next_tick(0, 16'h0, 4'h0);

        next_tick(1, 16'h8888, 4'b0100);
        for (int i = 0; i < 3; i++) next_tick(0, 16'h0, 4'h0);

        for (int i = 0; i < 4 && bidx != 2'd2; i++) next_tick(0, 16'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        sample(1'b0);
        rst = 1'b1; load = 1'b1; value = 16'h7777;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_l", {an_l, seg_l, dp_l, tk_l}, {4'hF, 7'h7F, 1'b1, 1'b0});
        chk("mid_rst_h", {an_h, seg_h, dp_h, tk_h}, 13'h0);
        chk("mid_rst_pre", {10'd0, dut_h.pre_q}, 12'd0);
        chk("mid_rst_idx", {10'd0, dut_h.idx_q}, 12'd0);
        rst = 1'b0; load = 1'b0; value = 16'h0;
        mval = 16'h0; mdp = 4'h0; bidx = 2'd0;
        next_tick(0, 16'h0, 4'h0);
        next_tick(0, 16'h0, 4'h0);

        chk("queue_left", q.size(), 12'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
